// File: rtl/subtractor_divider_ctrl.sv
// Sequential restoring divider: one trial subtraction per clock on a shared
// borrow-out subtractor, N iterations per operation, result with a done pulse.

// Ripple-borrow subtractor: diff = a - b - bin, bout set when the result underflows.
module subtractor #(
  parameter int unsigned W = 5
) (
  input  logic [W-1:0] a,
  input  logic [W-1:0] b,
  input  logic         bin,
  output logic [W-1:0] diff,
  output logic         bout
);

  // Bit-serial borrow chain, evaluated LSB first within one block.
  always_comb begin
    logic [W:0] brw;
    brw     = '0;
    diff    = '0;
    brw[0]  = bin;
    for (int i = 0; i < int'(W); i++) begin
      diff[i]  = a[i] ^ b[i] ^ brw[i];
      brw[i+1] = (~a[i] & b[i]) | (~(a[i] ^ b[i]) & brw[i]);
    end
    bout = brw[W];
  end

endmodule

module subtractor_divider_ctrl #(
  parameter int unsigned N = 4
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  input  logic [N-1:0] dividend,
  input  logic [N-1:0] divisor,
  output logic         busy,
  output logic         done,
  output logic [N-1:0] quotient,
  output logic [N-1:0] remainder,
  output logic         div_zero
);

  localparam int unsigned CW = $clog2(N) + 1;
  localparam int unsigned SW = N + 1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;
  state_t state_next;

  // Working registers: Q shifts dividend bits out / quotient bits in, R is the
  // partial remainder, D holds the divisor for the whole operation.
  logic [N-1:0]  q_reg;
  logic [N-1:0]  r_reg;
  logic [N-1:0]  d_reg;
  logic [CW-1:0] cnt;

  logic [N-1:0]  q_next;
  logic [N-1:0]  r_next;
  logic [N-1:0]  d_next;
  logic [CW-1:0] cnt_next;
  logic [N-1:0]  quotient_next;
  logic [N-1:0]  remainder_next;
  logic          div_zero_next;
  logic          busy_next;
  logic          done_next;

  logic [SW-1:0] sub_a;
  logic [SW-1:0] sub_b;
  logic [N-1:0]  sub_diff;
  logic          unused_diff_msb;
  logic          sub_bout;

  logic          divisor_zero;
  logic          last_iter;
  logic [N-1:0]  q_step;
  logic [N-1:0]  r_step;

  // Trial operands: shift the next dividend bit into the partial remainder.
  assign sub_a = {r_reg, q_reg[N-1]};
  assign sub_b = {1'b0, d_reg};

  // The single shared subtractor; its MSB is always 0 when no borrow occurs.
  subtractor #(
    .W (SW)
  ) u_sub (
    .a    (sub_a),
    .b    (sub_b),
    .bin  (1'b0),
    .diff ({unused_diff_msb, sub_diff}),
    .bout (sub_bout)
  );

  assign divisor_zero = (divisor == '0);
  assign last_iter    = (cnt == CW'(N - 1));

  // Restoring step: keep the difference on success, restore the shifted value on borrow.
  always_comb begin
    if (sub_bout) begin
      r_step = sub_a[N-1:0];
      q_step = {q_reg[N-2:0], 1'b0};
    end else begin
      r_step = sub_diff;
      q_step = {q_reg[N-2:0], 1'b1};
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (start) begin
          state_next = divisor_zero ? DONE : RUN;
        end
      end
      RUN: begin
        if (last_iter) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Datapath and output next values, hold by default.
  always_comb begin
    q_next         = q_reg;
    r_next         = r_reg;
    d_next         = d_reg;
    cnt_next       = cnt;
    quotient_next  = quotient;
    remainder_next = remainder;
    div_zero_next  = div_zero;
    case (state)
      IDLE: begin
        if (start) begin
          if (divisor_zero) begin
            quotient_next  = '1;
            remainder_next = dividend;
            div_zero_next  = 1'b1;
          end else begin
            q_next        = dividend;
            r_next        = '0;
            d_next        = divisor;
            cnt_next      = '0;
            div_zero_next = 1'b0;
          end
        end
      end
      RUN: begin
        q_next   = q_step;
        r_next   = r_step;
        cnt_next = cnt + CW'(1);
        if (last_iter) begin
          quotient_next  = q_step;
          remainder_next = r_step;
        end
      end
      default: begin
      end
    endcase
    busy_next = (state_next == RUN);
    done_next = (state_next == DONE);
  end

  // Datapath and registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      q_reg     <= '0;
      r_reg     <= '0;
      d_reg     <= '0;
      cnt       <= '0;
      quotient  <= '0;
      remainder <= '0;
      div_zero  <= 1'b0;
      busy      <= 1'b0;
      done      <= 1'b0;
    end else begin
      q_reg     <= q_next;
      r_reg     <= r_next;
      d_reg     <= d_next;
      cnt       <= cnt_next;
      quotient  <= quotient_next;
      remainder <= remainder_next;
      div_zero  <= div_zero_next;
      busy      <= busy_next;
      done      <= done_next;
    end
  end

endmodule

// File: tb/tb_subtractor_divider_ctrl.sv
// Self-checking bench for subtractor_divider_ctrl (N=4): directed cases,
// divide-by-zero, ignored start, mid-run reset, random and exhaustive sweeps
// against a plain-arithmetic reference.
module tb_subtractor_divider_ctrl;

  localparam int N = 4;

  logic         clk;
  logic         rst;
  logic         start;
  logic [N-1:0] dividend;
  logic [N-1:0] divisor;
  logic         busy;
  logic         done;
  logic [N-1:0] quotient;
  logic [N-1:0] remainder;
  logic         div_zero;

  int tests;
  int fails;

  subtractor_divider_ctrl #(.N(N)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .dividend  (dividend),
    .divisor   (divisor),
    .busy      (busy),
    .done      (done),
    .quotient  (quotient),
    .remainder (remainder),
    .div_zero  (div_zero)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: unsigned division, divisor 0 gives all-ones / dividend / flag.
  function automatic logic [N-1:0] ref_q(input logic [N-1:0] a, input logic [N-1:0] b);
    if (b == 0) return {N{1'b1}};
    return N'(int'(a) / int'(b));
  endfunction

  function automatic logic [N-1:0] ref_r(input logic [N-1:0] a, input logic [N-1:0] b);
    if (b == 0) return a;
    return N'(int'(a) % int'(b));
  endfunction

  // Drive one operation and observe it. edges counts clock edges from the one
  // sampling start (inclusive) to the first cycle with done high.
  task automatic run_op(input logic [N-1:0] a, input logic [N-1:0] b,
                        output logic [N-1:0] q, output logic [N-1:0] r,
                        output logic dz, output int busy_cyc, output int edges,
                        output logic timeout, output logic busy_at_done,
                        output logic done_after);
    @(negedge clk);
    dividend = a;
    divisor  = b;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start    = 1'b0;
    edges    = 1;
    busy_cyc = 0;
    timeout  = 1'b1;
    for (int i = 0; i < 3 * N + 4; i++) begin
      if (done) begin
        timeout = 1'b0;
        break;
      end
      if (busy) busy_cyc++;
      @(posedge clk);
      #1;
      edges++;
    end
    q            = quotient;
    r            = remainder;
    dz           = div_zero;
    busy_at_done = busy;
    @(posedge clk);
    #1;
    done_after = done;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    start = 1'b0;
    dividend = '0;
    divisor = '0;
    repeat (2) @(posedge clk);
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy got=%b exp=0", busy); end
    tests++; if (done !== 1'b0) begin fails++; $display("FAIL reset_done got=%b exp=0", done); end
    tests++; if (quotient !== '0) begin fails++; $display("FAIL reset_q got=%0d exp=0", quotient); end
    tests++; if (remainder !== '0) begin fails++; $display("FAIL reset_r got=%0d exp=0", remainder); end
    tests++; if (div_zero !== 1'b0) begin fails++; $display("FAIL reset_dz got=%b exp=0", div_zero); end
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_directed();
    logic [N-1:0] av [5] = '{4'd13, 4'd15, 4'd0, 4'd2, 4'd1};
    logic [N-1:0] bv [5] = '{4'd3, 4'd15, 4'd1, 4'd1, 4'd2};
    logic [N-1:0] eq [5] = '{4'd4, 4'd1, 4'd0, 4'd2, 4'd0};
    logic [N-1:0] er [5] = '{4'd1, 4'd0, 4'd0, 4'd0, 4'd1};
    logic [N-1:0] q, r;
    logic dz, to, bd, da;
    int bc, ed;
    for (int k = 0; k < 5; k++) begin
      run_op(av[k], bv[k], q, r, dz, bc, ed, to, bd, da);
      tests++; if (to !== 1'b0) begin fails++; $display("FAIL dir_timeout %0d/%0d no done", av[k], bv[k]); end
      tests++; if (q !== eq[k]) begin fails++; $display("FAIL dir_q %0d/%0d got=%0d exp=%0d", av[k], bv[k], q, eq[k]); end
      tests++; if (r !== er[k]) begin fails++; $display("FAIL dir_r %0d/%0d got=%0d exp=%0d", av[k], bv[k], r, er[k]); end
      tests++; if (dz !== 1'b0) begin fails++; $display("FAIL dir_dz %0d/%0d got=%b exp=0", av[k], bv[k], dz); end
      tests++; if (bc != N) begin fails++; $display("FAIL dir_busy_cycles %0d/%0d got=%0d exp=%0d", av[k], bv[k], bc, N); end
      tests++; if (ed != N + 1) begin fails++; $display("FAIL dir_latency %0d/%0d got=%0d exp=%0d", av[k], bv[k], ed, N + 1); end
      tests++; if (bd !== 1'b0) begin fails++; $display("FAIL dir_busy_with_done got=%b exp=0", bd); end
      tests++; if (da !== 1'b0) begin fails++; $display("FAIL dir_done_width got=%b exp=0", da); end
    end
  endtask

  task automatic test_div_zero();
    logic [N-1:0] q, r;
    logic dz, to, bd, da;
    int bc, ed;
    run_op(4'd7, 4'd0, q, r, dz, bc, ed, to, bd, da);
    tests++; if (to !== 1'b0) begin fails++; $display("FAIL dz_timeout no done"); end
    tests++; if (q !== 4'b1111) begin fails++; $display("FAIL dz_q got=%0d exp=15", q); end
    tests++; if (r !== 4'd7) begin fails++; $display("FAIL dz_r got=%0d exp=7", r); end
    tests++; if (dz !== 1'b1) begin fails++; $display("FAIL dz_flag got=%b exp=1", dz); end
    tests++; if (ed != 1) begin fails++; $display("FAIL dz_latency got=%0d exp=1", ed); end
    tests++; if (bc != 0) begin fails++; $display("FAIL dz_busy got=%0d exp=0", bc); end
    tests++; if (da !== 1'b0) begin fails++; $display("FAIL dz_done_width got=%b exp=0", da); end
    // A following normal op clears the flag.
    run_op(4'd9, 4'd2, q, r, dz, bc, ed, to, bd, da);
    tests++; if (dz !== 1'b0 || q !== 4'd4 || r !== 4'd1) begin
      fails++; $display("FAIL dz_clear got q=%0d r=%0d dz=%b exp q=4 r=1 dz=0", q, r, dz);
    end
  endtask

  task automatic test_ignore_start();
    int pulses;
    logic [N-1:0] q_seen, r_seen;
    @(negedge clk);
    dividend = 4'd13;
    divisor  = 4'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    pulses = 0;
    q_seen = '0;
    r_seen = '0;
    @(negedge clk);
    dividend = 4'd9;
    divisor  = 4'd2;
    start    = 1'b1;
    repeat (2) begin
      @(posedge clk);
      #1;
      if (done) begin pulses++; q_seen = quotient; r_seen = remainder; end
    end
    start = 1'b0;
    for (int i = 0; i < 12; i++) begin
      @(posedge clk);
      #1;
      if (done) begin pulses++; q_seen = quotient; r_seen = remainder; end
    end
    tests++; if (pulses != 1) begin fails++; $display("FAIL ign_pulses got=%0d exp=1", pulses); end
    tests++; if (q_seen !== 4'd4) begin fails++; $display("FAIL ign_q got=%0d exp=4", q_seen); end
    tests++; if (r_seen !== 4'd1) begin fails++; $display("FAIL ign_r got=%0d exp=1", r_seen); end
    tests++; if (quotient !== 4'd4 || remainder !== 4'd1 || busy !== 1'b0) begin
      fails++; $display("FAIL ign_hold got q=%0d r=%0d busy=%b exp q=4 r=1 busy=0", quotient, remainder, busy);
    end
  endtask

  task automatic test_reset_mid_run();
    int pulses;
    logic [N-1:0] q, r;
    logic dz, to, bd, da;
    int bc, ed;
    @(negedge clk);
    dividend = 4'd13;
    divisor  = 4'd3;
    start    = 1'b1;
    @(posedge clk);
    #1;
    start = 1'b0;
    @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk);
    #1;
    tests++; if (busy !== 1'b0 || done !== 1'b0) begin
      fails++; $display("FAIL rstrun_ctl got busy=%b done=%b exp 0 0", busy, done);
    end
    tests++; if (quotient !== '0 || remainder !== '0 || div_zero !== 1'b0) begin
      fails++; $display("FAIL rstrun_out got q=%0d r=%0d dz=%b exp 0 0 0", quotient, remainder, div_zero);
    end
    @(negedge clk);
    rst = 1'b0;
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      if (done || busy) pulses++;
    end
    tests++; if (pulses != 0) begin fails++; $display("FAIL rstrun_activity got=%0d exp=0", pulses); end
    run_op(4'd6, 4'd4, q, r, dz, bc, ed, to, bd, da);
    tests++; if (to !== 1'b0 || q !== 4'd1 || r !== 4'd2 || dz !== 1'b0) begin
      fails++; $display("FAIL rstrun_after got q=%0d r=%0d dz=%b to=%b exp q=1 r=2 dz=0", q, r, dz, to);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] a, b, q, r;
    logic dz, to, bd, da;
    int bc, ed;
    for (int k = 0; k < 40; k++) begin
      a = N'($urandom);
      b = N'($urandom);
      run_op(a, b, q, r, dz, bc, ed, to, bd, da);
      tests++;
      if (to !== 1'b0 || q !== ref_q(a, b) || r !== ref_r(a, b) || dz !== (b == 0)) begin
        fails++;
        $display("FAIL rand %0d/%0d got q=%0d r=%0d dz=%b exp q=%0d r=%0d dz=%b", a, b, q, r, dz,
                 ref_q(a, b), ref_r(a, b), (b == 0));
      end
      tests++;
      if (ed != ((b == 0) ? 1 : N + 1)) begin
        fails++; $display("FAIL rand_latency %0d/%0d got=%0d exp=%0d", a, b, ed, (b == 0) ? 1 : N + 1);
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] q, r;
    logic dz, to, bd, da;
    int bc, ed;
    for (int a = 0; a < 16; a++) begin
      for (int b = 0; b < 16; b++) begin
        run_op(N'(a), N'(b), q, r, dz, bc, ed, to, bd, da);
        tests++;
        if (to !== 1'b0 || q !== ref_q(N'(a), N'(b)) || r !== ref_r(N'(a), N'(b)) || dz !== (b == 0)) begin
          fails++;
          $display("FAIL exh %0d/%0d got q=%0d r=%0d dz=%b exp q=%0d r=%0d dz=%b", a, b, q, r, dz,
                   ref_q(N'(a), N'(b)), ref_r(N'(a), N'(b)), (b == 0));
        end
      end
    end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    test_reset();
    test_directed();
    test_div_zero();
    test_ignore_start();
    test_reset_mid_run();
    test_random();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
